bit_serial_adder_ctrl: RTL and testbench
========================================

BIT_SERIAL_ADDER_CTRL -- requirements
Module: bit_serial_adder_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 Port start SHALL be an input, 1 bit wide: request to begin an operation; sampled only in IDLE.
REQ-005 Port sub SHALL be an input, 1 bit wide: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 Port a SHALL be an input, WIDTH bits wide: operand A; sampled with start.
REQ-007 Port b SHALL be an input, WIDTH bits wide: operand B; sampled with start.
REQ-008 Port ack SHALL be an input, 1 bit wide: consumer acknowledge of the result; honored only in DONE.
REQ-009 Port busy SHALL be an output, 1 bit wide: high whenever state is not IDLE.
REQ-010 Port done SHALL be an output, 1 bit wide: result valid; high only in DONE.
REQ-011 Port sum SHALL be an output, WIDTH bits wide: result; LSB first, one bit per cycle.
REQ-012 Port cout SHALL be an output, 1 bit wide: final carry; for subtraction, 1 = no borrow.
REQ-013 Port ovf SHALL be an output, 1 bit wide: signed two's-complement overflow.

Function
REQ-014 The datapath SHALL be a single 1-bit full adder (sum = x^y^c; carry = x&y | c&(x^y)) reused once per cycle; no WIDTH-bit adder is permitted.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 In IDLE with start=1, the controller SHALL do the following at the next edge: load A into shift register A; load B (sub=0) or ~B (sub=1) into shift register B; set the carry register to sub; clear sum; clear the bit counter; go to RUN.
REQ-017 Each RUN cycle SHALL add A[0], B[0] and carry.
REQ-018 In each RUN cycle, the result bit SHALL shift into sum from the MSB side (right shift), and A and B SHALL shift right.
REQ-019 In each RUN cycle, the carry register SHALL update and the bit counter SHALL increment.
REQ-020 When the counter reaches WIDTH-1 and that bit is processed, the FSM SHALL go to DONE.
REQ-021 On the DONE transition, cout SHALL be set to the final carry.
REQ-022 On the DONE transition, ovf SHALL be set to (carry into the MSB) XOR (carry out of the MSB).
REQ-023 Latency: done SHALL rise exactly WIDTH clock edges after the edge that accepted start.
REQ-024 Throughput SHALL be one operation per WIDTH+2 cycles minimum: accept, WIDTH processing edges, then one ack edge.
REQ-025 In DONE, sum, cout and ovf SHALL be held stable until ack=1; done SHALL stay high indefinitely without ack.
REQ-026 In DONE with ack=1, the FSM SHALL return to IDLE at the next edge and done SHALL fall; sum, cout and ovf SHALL retain their values until the next start is accepted.
REQ-027 start in RUN or DONE SHALL be ignored, with no queuing; start and ack together in DONE SHALL honor ack only, and no new operation begins on that edge.
REQ-028 ack outside DONE SHALL be ignored.
REQ-029 Changes to a, b or sub after the accepting edge SHALL NOT affect the in-flight result.
REQ-030 Result arithmetic SHALL be modulo 2^WIDTH.
REQ-031 For sub=1, {cout,sum} SHALL equal a + ~b + 1.
REQ-032 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-033 With reset=1 at an edge, the block SHALL enter IDLE and clear busy, done, sum, cout, ovf, the carry register, the counter and both shift registers.
REQ-034 reset SHALL override start and ack in the same cycle.
REQ-035 A reset asserted mid-RUN or in DONE SHALL abort the operation with no partial result visible, and the next start after reset deasserts SHALL execute normally.

Verification (WIDTH=8)
REQ-036 A bench SHALL verify: a=8'h0F, b=8'h01, sub=0, start -> 8 edges later done=1, sum=8'h10, cout=0, ovf=0.
REQ-037 A bench SHALL verify: a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
REQ-038 A bench SHALL verify: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0, ovf=0; a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, ovf=1.
REQ-039 A bench SHALL verify: reset pulsed on the 3rd RUN cycle -> next edge busy=0, done=0, sum=0; a following start with a=3, b=4 -> sum=8'h07 after 8 edges.
REQ-040 A bench SHALL verify: start pulsed during RUN with different operands -> result is unchanged; start+ack together in DONE -> IDLE, busy=0, and no new operation begins.
REQ-041 A bench SHALL run an exhaustive sweep over all a, b and sub for WIDTH=4 against a reference {cout,sum}=a+b (or a+~b+1), printing PASS/FAIL per vector.

Source files
------------

// File: rtl/bit_serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder controller.
// The master side issues operations and acknowledges results; the slave side
// is the controller itself.
interface bit_serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ack;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, ack,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, ack,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial add/subtract controller.
// One full adder is reused once per cycle, LSB first. Subtraction is done as
// a + ~b + 1 by inverting B at load time and seeding the carry with 1.
//
// state | meaning
// IDLE  | waiting for start; last result held on sum/cout/ovf
// RUN   | one operand bit pair processed per cycle
// DONE  | result valid and frozen until ack
module bit_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    bit_serial_adder_ctrl_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_carry = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last_bit = (cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; start only matters in IDLE and ack only in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    if (bus.ack)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand load on accept, one adder step per RUN cycle, and
    // final carry/overflow capture on the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b ^ {WIDTH{bus.sub}};
                        carry  <= bus.sub;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    sum_q <= {fa_sum, sum_q[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        cout_q <= fa_carry;
                        ovf_q  <= carry ^ fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Bench for the bit-serial adder controller: directed corner cases and
// randomized operations on an 8-bit instance, plus a full sweep of a 4-bit
// instance, all against an arithmetic reference model.
module tb_bit_serial_adder_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_mis;

    bit_serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    bit_serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

    bit_serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    bit_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: modulo 2^w add or subtract, carry out, signed overflow.
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit sub, output longint unsigned s, output bit co, output bit ov);
        longint unsigned mask;
        longint unsigned t;
        bit sa, sb, ss;
        mask = (64'd1 << w) - 1;
        t    = sub ? (a + ((~b) & mask) + 1) : (a + b);
        s    = t & mask;
        co   = t[w];
        sa   = a[w-1];
        sb   = b[w-1];
        ss   = s[w-1];
        ov   = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 8-bit operation; caller is in IDLE, 1 time unit after an edge.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sub,
                        input bit noise, input int hold, input bit ack_with_start, input string tag);
        longint unsigned es;
        bit ec, eo;
        model(8, 64'(a), 64'(b), sub, es, ec, eo);
        bus8.a = a; bus8.b = b; bus8.sub = sub; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = 1'($urandom_range(0, 1));
        check_val({tag, "/busy_run"}, 64'(bus8.busy), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            if (noise) begin
                bus8.start = 1'($urandom_range(0, 1));
                bus8.ack   = 1'($urandom_range(0, 1));
                bus8.a     = 8'($urandom);
                bus8.b     = 8'($urandom);
            end
            tick();
            bus8.start = 1'b0;
            bus8.ack   = 1'b0;
            if (i == 7) check_val({tag, "/done_early"}, 64'(bus8.done), 64'd0);
        end
        check_val({tag, "/done"}, 64'(bus8.done), 64'd1);
        check_val({tag, "/sum"},  64'(bus8.sum),  es);
        check_val({tag, "/cout"}, 64'(bus8.cout), 64'(ec));
        check_val({tag, "/ovf"},  64'(bus8.ovf),  64'(eo));
        if (hold > 0) begin
            repeat (hold) tick();
            check_val({tag, "/done_hold"}, 64'(bus8.done), 64'd1);
            check_val({tag, "/sum_hold"},  64'({bus8.cout, bus8.ovf, bus8.sum}), 64'({ec, eo, es[7:0]}));
        end
        bus8.ack = 1'b1;
        if (ack_with_start) begin
            bus8.start = 1'b1;
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        end
        tick();
        bus8.ack = 1'b0;
        bus8.start = 1'b0;
        check_val({tag, "/busy_ack"}, 64'(bus8.busy), 64'd0);
        check_val({tag, "/done_ack"}, 64'(bus8.done), 64'd0);
        check_val({tag, "/sum_kept"}, 64'(bus8.sum), es);
        if (ack_with_start) begin
            tick();
            check_val({tag, "/no_new_op"}, 64'(bus8.busy), 64'd0);
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input bit sub);
        longint unsigned es;
        bit ec, eo;
        model(4, 64'(a), 64'(b), sub, es, ec, eo);
        bus4.a = a; bus4.b = b; bus4.sub = sub; bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        repeat (4) tick();
        check_val($sformatf("w4 %0h%s%0h done", a, sub ? "-" : "+", b), 64'(bus4.done), 64'd1);
        check_val($sformatf("w4 %0h%s%0h cout_sum", a, sub ? "-" : "+", b),
                  64'({bus4.cout, bus4.sum}), 64'({ec, es[3:0]}));
        check_val($sformatf("w4 %0h%s%0h ovf", a, sub ? "-" : "+", b), 64'(bus4.ovf), 64'(eo));
        bus4.ack = 1'b1;
        tick();
        bus4.ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_mis = 0;
        reset = 1'b1;
        bus8.start = 0; bus8.sub = 0; bus8.a = 0; bus8.b = 0; bus8.ack = 0;
        bus4.start = 0; bus4.sub = 0; bus4.a = 0; bus4.b = 0; bus4.ack = 0;
        bus8.start = 1'b1;
        bus8.ack   = 1'b1;
        tick();
        tick();
        check_val("rst/busy", 64'(bus8.busy), 64'd0);
        check_val("rst/done", 64'(bus8.done), 64'd0);
        check_val("rst/outs", 64'({bus8.cout, bus8.ovf, bus8.sum}), 64'd0);
        bus8.start = 1'b0;
        bus8.ack   = 1'b0;
        reset = 1'b0;
        tick();
        check_val("idle/busy", 64'(bus8.busy), 64'd0);

        run8(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b0, "add_0f_01");
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 3, 1'b0, "add_ff_01");
        run8(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0, "add_7f_01");
        run8(8'h05, 8'h07, 1'b1, 1'b0, 0, 1'b0, "sub_05_07");
        run8(8'h80, 8'h01, 1'b1, 1'b0, 5, 1'b0, "sub_80_01");
        run8(8'h12, 8'h34, 1'b0, 1'b1, 2, 1'b1, "noise_start_ack");
        run8(8'h00, 8'h00, 1'b1, 1'b0, 0, 1'b0, "sub_00_00");

        // Reset on the third RUN cycle.
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.sub = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_run/busy", 64'(bus8.busy), 64'd0);
        check_val("rst_run/done", 64'(bus8.done), 64'd0);
        check_val("rst_run/outs", 64'({bus8.cout, bus8.ovf, bus8.sum}), 64'd0);
        repeat (5) tick();   // the 4-bit instance was also reset; let it settle idle
        run8(8'h03, 8'h04, 1'b0, 1'b0, 0, 1'b0, "after_rst_run");

        // Reset while holding a result in DONE.
        bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.sub = 1'b0; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (8) tick();
        check_val("rst_done/pre", 64'(bus8.done), 64'd1);
        reset = 1'b1;
        bus8.ack = 1'b1;
        tick();
        reset = 1'b0;
        bus8.ack = 1'b0;
        check_val("rst_done/done", 64'(bus8.done), 64'd0);
        check_val("rst_done/outs", 64'({bus8.cout, bus8.ovf, bus8.sum}), 64'd0);
        run8(8'h81, 8'h81, 1'b0, 1'b0, 0, 1'b0, "after_rst_done");

        for (int n = 0; n < 150; n++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
        end

        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run4(4'(x), 4'(y), 1'(s));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
